// File: rtl/debug_host_pkg.sv
// debug_host_pkg: protocol constants shared by the debug target and host,
// plus the host controller's state, acknowledge-context and error encodings.
package debug_host_pkg;

   // Default widths and sizes
   localparam int DH_NB_REG      = 32;
   localparam int DH_DBIT        = 8;
   localparam int DH_PROG_AW     = 6;
   localparam int DH_CAP_AW      = 9;
   localparam int DH_TIMEOUT_CYC = 1048576;

   // Command codes and protocol markers
   localparam logic [7:0]  CMD_LOAD  = 8'h02;
   localparam logic [7:0]  CMD_RUN   = 8'h05;
   localparam logic [7:0]  CMD_RESET = 8'h0C;
   localparam logic [7:0]  ACK_BYTE  = 8'hAA;
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   // Post-halt dump layout: registers, memory words, pipeline latches
   localparam int N_REG_BYTES   = 128;
   localparam int N_MEM_BYTES   = 128;
   localparam int N_LATCH_BYTES = 43;
   localparam int DH_N_DUMP     = N_REG_BYTES + N_MEM_BYTES + N_LATCH_BYTES;

   // Sticky error codes reported on o_error
   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_BAD_ACK = 2'b01,
      ERR_NO_HALT = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_e;

   // Host controller states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_RST,
      ST_SEND_LOAD,
      ST_WAIT_ACK,
      ST_FETCH,
      ST_LATCH,
      ST_SEND_BYTE,
      ST_SEND_RUN,
      ST_RECV,
      ST_DONE,
      ST_ERROR
   } state_e;

   // What an accepted ACK resumes into
   typedef enum logic [1:0] {
      ACK_AFTER_LOAD,
      ACK_AFTER_BYTE,
      ACK_AFTER_RUN
   } ack_ctx_e;

   // Select byte idx of a word, byte 0 being bits 31:24
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/debug_host_wdog.sv
// debug_host_wdog: stall watchdog for the debug host. Only instantiated when
// DH_TIMEOUT_EN is defined. Counts stalled cycles, restarts on any UART
// transfer, and flags expiry once TIMEOUT_CYC stalled cycles accumulate.
module debug_host_wdog
   import debug_host_pkg::*;
#(
   parameter int TIMEOUT_CYC = DH_TIMEOUT_CYC
)(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

   logic [CW-1:0] stall_cnt;

   assign o_expired = (stall_cnt == LIMIT);

   // Stall counter: cleared by transfers, saturates at the limit
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         stall_cnt <= '0;
      end else if (i_count_en && !o_expired) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/debug_host.sv
// debug_host: initiator end of the MIPS debug UART protocol. Streams a program
// from a word ROM with LOAD and per-byte ACKs, issues RUN, captures the 299-byte
// post-halt dump, and can send the target RESET command on its own.
// Optional stall watchdog enabled by defining DH_TIMEOUT_EN.
module debug_host
   import debug_host_pkg::*;
#(
   parameter int NB_REG      = DH_NB_REG,
   parameter int DBIT        = DH_DBIT,
   parameter int PROG_AW     = DH_PROG_AW,
   parameter int CAP_AW      = DH_CAP_AW,
   parameter int N_DUMP      = DH_N_DUMP,
   parameter int TIMEOUT_CYC = DH_TIMEOUT_CYC
)(
   input  logic               i_dh_clk,
   input  logic               i_dh_reset,
   input  logic               i_start,
   input  logic               i_tgt_reset,
   input  logic               i_rx_empty,
   input  logic [DBIT-1:0]    i_rx_data,
   output logic               o_rd_uart,
   input  logic               i_tx_full,
   output logic               o_wr_uart,
   output logic [DBIT-1:0]    o_tx_data,
   output logic [PROG_AW-1:0] o_prog_addr,
   input  logic [NB_REG-1:0]  i_prog_data,
   output logic               o_cap_we,
   output logic [CAP_AW-1:0]  o_cap_addr,
   output logic [DBIT-1:0]    o_cap_data,
   output logic               o_busy,
   output logic               o_done,
   output logic [1:0]         o_error
);

   localparam logic [CAP_AW-1:0]  LAST_IDX = CAP_AW'(N_DUMP - 1);
   localparam logic [CAP_AW-1:0]  DUMP_LEN = CAP_AW'(N_DUMP);
   localparam logic [PROG_AW-1:0] ADDR_MAX = '1;

   state_e              state_q,     state_d;
   ack_ctx_e            ctx_q,       ctx_d;
   logic [PROG_AW-1:0]  prog_addr_q, prog_addr_d;
   logic [NB_REG-1:0]   word_q,      word_d;
   logic [1:0]          byte_idx_q,  byte_idx_d;
   logic [CAP_AW-1:0]   rx_cnt_q,    rx_cnt_d;
   logic                cap_we_q,    cap_we_d;
   logic [CAP_AW-1:0]   cap_addr_q,  cap_addr_d;
   logic [DBIT-1:0]     cap_data_q,  cap_data_d;
   err_e                error_q,     error_d;

   logic                push;
   logic                pop;
   logic [DBIT-1:0]     tx_byte;
   logic                timeout_hit;

`ifdef DH_TIMEOUT_EN
   logic in_wait_state;
   logic stalled;
   logic wdog_expired;

   assign in_wait_state = (state_q == ST_WAIT_ACK) || (state_q == ST_RECV) ||
                          (state_q == ST_SEND_RST) || (state_q == ST_SEND_LOAD) ||
                          (state_q == ST_SEND_BYTE) || (state_q == ST_SEND_RUN);
   assign stalled = (state_q == ST_WAIT_ACK) || (state_q == ST_RECV) ||
                    (i_tx_full && ((state_q == ST_SEND_RST) || (state_q == ST_SEND_LOAD) ||
                                   (state_q == ST_SEND_BYTE) || (state_q == ST_SEND_RUN)));

   debug_host_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .i_clk      (i_dh_clk),
      .i_reset    (i_dh_reset),
      .i_clear    (push || pop || (state_q == ST_IDLE)),
      .i_count_en (stalled),
      .o_expired  (wdog_expired)
   );

   assign timeout_hit = wdog_expired && in_wait_state;
`else
   assign timeout_hit = 1'b0;
`endif

   // Reset aborts at once: no push or pop in the cycle reset is asserted
   assign o_wr_uart   = push && !i_dh_reset;
   assign o_rd_uart   = pop && !i_dh_reset;
   assign o_tx_data   = tx_byte;
   assign o_prog_addr = prog_addr_q;
   assign o_cap_we    = cap_we_q;
   assign o_cap_addr  = cap_addr_q;
   assign o_cap_data  = cap_data_q;
   assign o_error     = error_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE) || (state_q == ST_ERROR);

   // Next-state, datapath updates and UART handshakes for the whole sequence
   always_comb begin
      state_d     = state_q;
      ctx_d       = ctx_q;
      prog_addr_d = prog_addr_q;
      word_d      = word_q;
      byte_idx_d  = byte_idx_q;
      rx_cnt_d    = rx_cnt_q;
      cap_we_d    = 1'b0;
      cap_addr_d  = cap_addr_q;
      cap_data_d  = cap_data_q;
      error_d     = error_q;
      push        = 1'b0;
      pop         = 1'b0;
      tx_byte     = '0;

      if (timeout_hit) begin
         error_d = ERR_TIMEOUT;
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_tgt_reset) begin
                  error_d = ERR_NONE;
                  state_d = ST_SEND_RST;
               end else if (i_start) begin
                  error_d     = ERR_NONE;
                  prog_addr_d = '0;
                  rx_cnt_d    = '0;
                  state_d     = ST_SEND_LOAD;
               end
            end

            ST_SEND_RST: begin
               tx_byte = CMD_RESET;
               if (!i_tx_full) begin
                  push    = 1'b1;
                  state_d = ST_DONE;
               end
            end

            ST_SEND_LOAD: begin
               tx_byte = CMD_LOAD;
               if (!i_tx_full) begin
                  push    = 1'b1;
                  ctx_d   = ACK_AFTER_LOAD;
                  state_d = ST_WAIT_ACK;
               end
            end

            ST_WAIT_ACK: begin
               if (!i_rx_empty) begin
                  pop = 1'b1;
                  if (i_rx_data != ACK_BYTE) begin
                     error_d = ERR_BAD_ACK;
                     state_d = ST_ERROR;
                  end else begin
                     case (ctx_q)
                        ACK_AFTER_LOAD: state_d = ST_FETCH;
                        ACK_AFTER_BYTE: begin
                           if (byte_idx_q != 2'd3) begin
                              byte_idx_d = byte_idx_q + 2'd1;
                              state_d    = ST_SEND_BYTE;
                           end else if (word_q == HALT_WORD) begin
                              state_d = ST_SEND_RUN;
                           end else if (prog_addr_q == ADDR_MAX) begin
                              error_d = ERR_NO_HALT;
                              state_d = ST_ERROR;
                           end else begin
                              prog_addr_d = prog_addr_q + 1'b1;
                              state_d     = ST_FETCH;
                           end
                        end
                        default: begin
                           rx_cnt_d = '0;
                           state_d  = ST_RECV;
                        end
                     endcase
                  end
               end
            end

            ST_FETCH: state_d = ST_LATCH;

            ST_LATCH: begin
               word_d     = i_prog_data;
               byte_idx_d = 2'd0;
               state_d    = ST_SEND_BYTE;
            end

            ST_SEND_BYTE: begin
               tx_byte = word_byte(word_q, byte_idx_q);
               if (!i_tx_full) begin
                  push    = 1'b1;
                  ctx_d   = ACK_AFTER_BYTE;
                  state_d = ST_WAIT_ACK;
               end
            end

            ST_SEND_RUN: begin
               tx_byte = CMD_RUN;
               if (!i_tx_full) begin
                  push    = 1'b1;
                  ctx_d   = ACK_AFTER_RUN;
                  state_d = ST_WAIT_ACK;
               end
            end

            ST_RECV: begin
               if (cap_we_q && (cap_addr_q == LAST_IDX)) begin
                  state_d = ST_DONE;
               end else if ((rx_cnt_q != DUMP_LEN) && !i_rx_empty) begin
                  pop        = 1'b1;
                  cap_we_d   = 1'b1;
                  cap_addr_d = rx_cnt_q;
                  cap_data_d = i_rx_data;
                  rx_cnt_d   = rx_cnt_q + 1'b1;
               end
            end

            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_dh_clk) begin
      if (i_dh_reset) begin
         state_q     <= ST_IDLE;
         ctx_q       <= ACK_AFTER_LOAD;
         prog_addr_q <= '0;
         word_q      <= '0;
         byte_idx_q  <= '0;
         rx_cnt_q    <= '0;
         cap_we_q    <= 1'b0;
         cap_addr_q  <= '0;
         cap_data_q  <= '0;
         error_q     <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         prog_addr_q <= prog_addr_d;
         word_q      <= word_d;
         byte_idx_q  <= byte_idx_d;
         rx_cnt_q    <= rx_cnt_d;
         cap_we_q    <= cap_we_d;
         cap_addr_q  <= cap_addr_d;
         cap_data_q  <= cap_data_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host: self-checking bench for debug_host. A behavioural debug target
// (byte queues) answers the host, and expected byte streams are derived from the
// ROM contents and the protocol rules.
module tb_debug_host;

   localparam int NDUMP = 299;

   logic        clk = 1'b0;
   logic        i_dh_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_tgt_reset = 1'b0;
   logic        i_rx_empty = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        o_rd_uart;
   logic        i_tx_full = 1'b0;
   logic        o_wr_uart;
   logic [7:0]  o_tx_data;
   logic [5:0]  o_prog_addr;
   logic [31:0] i_prog_data;
   logic        o_cap_we;
   logic [8:0]  o_cap_addr;
   logic [7:0]  o_cap_data;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_error;

   always #5 clk = ~clk;

   debug_host #(.TIMEOUT_CYC(64)) dut (
      .i_dh_clk    (clk),
      .i_dh_reset  (i_dh_reset),
      .i_start     (i_start),
      .i_tgt_reset (i_tgt_reset),
      .i_rx_empty  (i_rx_empty),
      .i_rx_data   (i_rx_data),
      .o_rd_uart   (o_rd_uart),
      .i_tx_full   (i_tx_full),
      .o_wr_uart   (o_wr_uart),
      .o_tx_data   (o_tx_data),
      .o_prog_addr (o_prog_addr),
      .i_prog_data (i_prog_data),
      .o_cap_we    (o_cap_we),
      .o_cap_addr  (o_cap_addr),
      .o_cap_data  (o_cap_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_error     (o_error)
   );

   // Program ROM with one cycle of read latency
   logic [31:0] rom [64];
   logic [31:0] rom_q = 32'h0;
   always @(posedge clk) rom_q <= rom[o_prog_addr];
   assign i_prog_data = rom_q;

   // Target model state
   logic [7:0] rxq[$];
   logic [7:0] tx_log[$];
   logic [7:0] exp_tx[$];
   logic [7:0] cap_mem [NDUMP];
   int  cap_count, done_count, viol_count, seq_err, run_index;
   bit  silent, bad_first, bp_en;
   int  checks = 0;
   int  errors = 0;

   // Target reaction to one byte received from the host
   task automatic targetRespond(input logic [7:0] b);
      int idx;
      idx = tx_log.size() - 1;
      if (silent || b == 8'h0C) return;
      if (idx == 0 && bad_first) rxq.push_back(8'h55);
      else rxq.push_back(8'hAA);
      if (idx == run_index)
         for (int k = 0; k < NDUMP; k++) rxq.push_back(8'(k % 43));
   endtask

   // Observe handshakes mid-cycle, then update the target FIFOs after the edge
   always @(negedge clk) begin : monitor
      logic       do_pop, do_push;
      logic [7:0] b;
      do_pop  = o_rd_uart;
      do_push = o_wr_uart;
      b       = o_tx_data;
      if (o_wr_uart && i_tx_full) viol_count++;
      if (o_rd_uart && i_rx_empty) viol_count++;
      if (o_wr_uart && o_rd_uart) viol_count++;
      if (o_done) done_count++;
      if (o_cap_we) begin
         if (int'(o_cap_addr) != cap_count) seq_err++;
         if (int'(o_cap_addr) < NDUMP) cap_mem[o_cap_addr] = o_cap_data;
         cap_count++;
      end
      @(posedge clk);
      #1;
      if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
      if (do_push) begin
         tx_log.push_back(b);
         targetRespond(b);
      end
      i_rx_empty = (rxq.size() == 0);
      i_rx_data  = i_rx_empty ? 8'h00 : rxq[0];
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected host byte stream: LOAD, words MSB first up to HALT, then RUN
   task automatic buildExpected();
      exp_tx.delete();
      run_index = -1;
      exp_tx.push_back(8'h02);
      for (int w = 0; w < 64; w++) begin
         exp_tx.push_back(rom[w][31:24]);
         exp_tx.push_back(rom[w][23:16]);
         exp_tx.push_back(rom[w][15:8]);
         exp_tx.push_back(rom[w][7:0]);
         if (rom[w] == 32'hFC00_0000) begin
            run_index = exp_tx.size();
            exp_tx.push_back(8'h05);
            return;
         end
      end
   endtask

   task automatic clearModel();
      rxq.delete();
      tx_log.delete();
      cap_count  = 0;
      done_count = 0;
      for (int k = 0; k < NDUMP; k++) cap_mem[k] = 8'hxx;
      i_rx_empty = 1'b1;
      i_rx_data  = 8'h00;
   endtask

   task automatic applyStimulus(input bit start, input bit tgt);
      @(posedge clk); #2;
      i_start     = start;
      i_tgt_reset = tgt;
      @(posedge clk); #2;
      i_start     = 1'b0;
      i_tgt_reset = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      i_dh_reset = 1'b1;
      clearModel();
      repeat (2) @(posedge clk);
      #2;
      i_dh_reset = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         i_tx_full = bp_en ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (o_done) begin
            ok = 1'b1;
            break;
         end
      end
      i_tx_full = 1'b0;
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic checkRun(input string t, input bit ok, input logic [1:0] exp_err, input bit exp_dump);
      int n;
      checkOutput($sformatf("%s_finished", t), 64'(ok), 64'd1);
      checkOutput($sformatf("%s_done_count", t), 64'(done_count), 64'd1);
      checkOutput($sformatf("%s_error", t), 64'(o_error), 64'(exp_err));
      checkOutput($sformatf("%s_busy", t), 64'(o_busy), 64'd0);
      checkOutput($sformatf("%s_tx_len", t), 64'(tx_log.size()), 64'(exp_tx.size()));
      n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_tx%0d", t, i), 64'(tx_log[i]), 64'(exp_tx[i]));
      if (exp_dump) begin
         checkOutput($sformatf("%s_cap_count", t), 64'(cap_count), 64'(NDUMP));
         for (int k = 0; k < NDUMP; k++)
            checkOutput($sformatf("%s_cap%0d", t, k), 64'(cap_mem[k]), 64'(k % 43));
      end else begin
         checkOutput($sformatf("%s_cap_count", t), 64'(cap_count), 64'd0);
      end
   endtask

   function automatic logic [31:0] randWord();
      logic [31:0] w;
      do w = $urandom; while (w == 32'hFC00_0000);
      return w;
   endfunction

   function automatic logic [63:0] allOutputs();
      return 64'({o_rd_uart, o_wr_uart, o_tx_data, o_prog_addr, o_cap_we,
                  o_cap_addr, o_cap_data, o_busy, o_done, o_error});
   endfunction

   initial begin : stimulus
      bit ok;
      int sz, len;
      viol_count = 0;
      seq_err    = 0;
      silent     = 1'b0;
      bad_first  = 1'b0;
      bp_en      = 1'b0;
      for (int w = 0; w < 64; w++) rom[w] = 32'h0;

      // Reset state
      doReset();
      checkOutput("reset_outputs", allOutputs(), 64'd0);

      // Basic program, full load/run/dump
      $display("[TB] basic program");
      rom[0] = 32'h2008_0005;
      rom[1] = 32'hFC00_0000;
      buildExpected();
      clearModel();
      applyStimulus(1'b1, 1'b0);
      waitDone(3000, ok);
      checkRun("t1", ok, 2'b00, 1'b1);

      // Bad ACK to LOAD
      $display("[TB] bad ack");
      bad_first = 1'b1;
      clearModel();
      applyStimulus(1'b1, 1'b0);
      waitDone(200, ok);
      checkOutput("t2_finished", 64'(ok), 64'd1);
      checkOutput("t2_error", 64'(o_error), 64'd1);
      repeat (20) @(posedge clk);
      #2;
      checkOutput("t2_tx_len", 64'(tx_log.size()), 64'd1);
      checkOutput("t2_done_count", 64'(done_count), 64'd1);
      checkOutput("t2_error_held", 64'(o_error), 64'd1);
      bad_first = 1'b0;

      // Target reset wins over start, clears the sticky error
      $display("[TB] target reset priority");
      clearModel();
      applyStimulus(1'b1, 1'b1);
      waitDone(6, ok);
      checkOutput("t4_finished", 64'(ok), 64'd1);
      checkOutput("t4_tx_len", 64'(tx_log.size()), 64'd1);
      if (tx_log.size() > 0) checkOutput("t4_tx0", 64'(tx_log[0]), 64'h0C);
      checkOutput("t4_error", 64'(o_error), 64'd0);
      checkOutput("t4_done_count", 64'(done_count), 64'd1);
      checkOutput("t4_prog_addr", 64'(o_prog_addr), 64'd0);

      // TX full held 50 cycles mid-word
      $display("[TB] tx backpressure");
      for (int w = 0; w < 64; w++) rom[w] = randWord();
      rom[3] = 32'hFC00_0000;
      buildExpected();
      clearModel();
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 200 && tx_log.size() < 3; i++) begin
         @(posedge clk); #2;
      end
      i_tx_full = 1'b1;
      sz = tx_log.size();
      repeat (50) @(posedge clk);
      #2;
      checkOutput("t3_no_push_when_full", 64'(tx_log.size()), 64'(sz));
      checkOutput("t3_busy_when_full", 64'(o_busy), 64'd1);
      i_tx_full = 1'b0;
      waitDone(3000, ok);
      checkRun("t3", ok, 2'b00, 1'b1);

      // Random programs with random backpressure
      for (int r = 0; r < 2; r++) begin
         $display("[TB] random program %0d", r);
         len = $urandom_range(1, 12);
         for (int w = 0; w < 64; w++) rom[w] = randWord();
         rom[len] = 32'hFC00_0000;
         buildExpected();
         clearModel();
         bp_en = 1'b1;
         applyStimulus(1'b1, 1'b0);
         waitDone(6000, ok);
         bp_en = 1'b0;
         checkRun($sformatf("rnd%0d", r), ok, 2'b00, 1'b1);
      end

      // ROM without a HALT word
      $display("[TB] no halt");
      for (int w = 0; w < 64; w++) rom[w] = randWord();
      buildExpected();
      clearModel();
      applyStimulus(1'b1, 1'b0);
      waitDone(5000, ok);
      checkRun("nohalt", ok, 2'b10, 1'b0);

      // Reset during the dump, then a clean restart from address 0
      $display("[TB] reset during dump");
      for (int w = 0; w < 64; w++) rom[w] = 32'h0;
      rom[0] = 32'h2008_0005;
      rom[1] = 32'hFC00_0000;
      buildExpected();
      clearModel();
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 2000 && cap_count < 100; i++) begin
         @(posedge clk); #2;
      end
      checkOutput("t5_reached_byte100", 64'(cap_count >= 100), 64'd1);
      i_dh_reset = 1'b1;
      @(posedge clk); #2;
      checkOutput("t5_outputs_after_reset", allOutputs(), 64'd0);
      clearModel();
      @(posedge clk); #2;
      i_dh_reset = 1'b0;
      applyStimulus(1'b1, 1'b0);
      waitDone(3000, ok);
      checkRun("t5", ok, 2'b00, 1'b1);

      // Silent target after LOAD
      $display("[TB] silent target");
      silent = 1'b1;
      clearModel();
      applyStimulus(1'b1, 1'b0);
`ifdef DH_TIMEOUT_EN
      waitDone(200, ok);
      checkOutput("t6_finished", 64'(ok), 64'd1);
      checkOutput("t6_error", 64'(o_error), 64'd3);
      checkOutput("t6_done_count", 64'(done_count), 64'd1);
`else
      repeat (200) @(posedge clk);
      #2;
      checkOutput("t6_busy", 64'(o_busy), 64'd1);
      checkOutput("t6_error", 64'(o_error), 64'd0);
      checkOutput("t6_done_count", 64'(done_count), 64'd0);
`endif
      checkOutput("t6_tx_len", 64'(tx_log.size()), 64'd1);
      silent = 1'b0;
      doReset();

      // Handshake rules across the whole run
      checkOutput("handshake_violations", 64'(viol_count), 64'd0);
      checkOutput("capture_sequence", 64'(seq_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_host.md
Name: debug_host

Overview:
- Initiator end of the MIPS debug UART protocol. Host-side FPGA controller that drives a debug target over a UART FIFO interface.
- Streams a program from a word ROM using LOAD (0x02) with per-byte ACK checking, then issues RUN (0x05).
- Captures the post-halt dump (32 regs, 32 mem words, 43 latch bytes = 299 bytes) into a byte buffer.
- Also issues the target RESET command (0x0C) on request.

Parameters:
- NB_REG, 32, instruction word width
- DBIT, 8, UART byte width
- PROG_AW, 6, program ROM word-address width
- CAP_AW, 9, capture buffer address width
- N_DUMP, 299, dump byte count (128 reg + 128 mem + 43 latch)
- TIMEOUT_CYC, 1048576, watchdog limit in cycles (used only when DH_TIMEOUT_EN is defined)

Ports:
- i_dh_clk  in  1  clock
- i_dh_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse: run full load/run/dump sequence
- i_tgt_reset  in  1  one-cycle pulse: send RESET command only
- i_rx_empty  in  1  UART RX FIFO empty
- i_rx_data  in  DBIT  RX FIFO head (show-ahead, valid while !i_rx_empty)
- o_rd_uart  out  1  pop RX FIFO
- i_tx_full  in  1  UART TX FIFO full
- o_wr_uart  out  1  push o_tx_data
- o_tx_data  out  DBIT  byte to transmit
- o_prog_addr  out  PROG_AW  program ROM word address
- i_prog_data  in  NB_REG  ROM data, one-cycle read latency
- o_cap_we  out  1  capture write strobe
- o_cap_addr  out  CAP_AW  capture byte address
- o_cap_data  out  DBIT  captured byte
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle completion pulse
- o_error  out  2  00 none, 01 bad ACK, 10 no HALT in ROM, 11 timeout; held until next start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately with no further UART pushes or pops. Target FIFOs are not flushed.
- Push rule: o_wr_uart asserts for exactly one cycle with o_tx_data stable, only when !i_tx_full.
- Pop rule: o_rd_uart asserts for exactly one cycle, only when !i_rx_empty. i_rx_data is sampled in that same cycle.
- IDLE:
  - i_tgt_reset takes priority over i_start when both arrive together.
  - i_start or i_tgt_reset clears o_error.
  - Both pulses are ignored while o_busy=1.
- Reset sequence: SEND_RST pushes 0x0C (no ACK expected), then DONE.
- Load sequence:
  - SEND_LOAD pushes 0x02, then WAIT_ACK.
  - FETCH drives o_prog_addr and waits one cycle for i_prog_data, then latches the word.
  - SEND_BYTE pushes word bytes MSB first (bits 31:24 first). Each byte is followed by WAIT_ACK.
  - After the 4th ACK: if the word == 0xFC000000, go to SEND_RUN. Otherwise increment o_prog_addr and go to FETCH.
  - If o_prog_addr wraps past 2^PROG_AW-1 without a HALT word: o_error=10, go to ERROR.
- WAIT_ACK: pops one byte. 0xAA resumes the sequence. Any other value sets o_error=01 and goes to ERROR.
- Run: SEND_RUN pushes 0x05, then WAIT_ACK, then RECV.
- RECV:
  - Each popped byte drives o_cap_we=1 on the following cycle, with o_cap_data = byte and o_cap_addr = index 0..N_DUMP-1.
  - Byte order is the target's order: reg0 MSB first … reg31, mem word 0 … 31, latch bytes MSB-first.
  - After byte N_DUMP-1 is written, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- ERROR: one cycle, o_done=1, then IDLE with o_error held.
- o_busy: 1 in every state except IDLE.
- A pop and a push never occur in the same cycle.

Optional Feature:
- DH_TIMEOUT_EN defined: a watchdog counter resets on every push or pop. It increments in WAIT_ACK, RECV and while blocked on i_tx_full. On reaching TIMEOUT_CYC: o_error=11, go to ERROR.
- Not defined: no counter; waits are unbounded.

Decomposition:
- Shared package holds the protocol constants, common to target and host:
  - command codes LOAD 0x02, RUN 0x05, RESET 0x0C
  - ACK 0xAA, HALT 0xFC000000
  - dump byte counts 128/128/43
  - error codes
  - state encoding
- One sub-module, debug_host_wdog (the timeout counter), instantiated only under DH_TIMEOUT_EN.

Test Plan:
1. ROM = {0x20080005, 0xFC000000}; target model ACKs every byte and dumps bytes 0x00..0x2A repeating → TX = 02,20,08,00,05,FC,00,00,00,05. Capture[k] matches the dump for k=0..298. One o_done, o_error=00.
2. Model answers 0x55 to the LOAD command → o_error=01, o_done pulse, no further o_wr_uart.
3. i_tx_full held high 50 cycles mid-word → no push while full; byte order unchanged after release.
4. i_tgt_reset and i_start asserted in the same cycle → single push 0x0C, o_done after it, no ROM fetch.
5. i_dh_reset during RECV at byte 100 → all outputs 0 next cycle. A subsequent i_start restarts from ROM address 0.
6. DH_TIMEOUT_EN, TIMEOUT_CYC=64, model silent after LOAD → o_error=11 after 64 cycles. Without the macro, o_busy stays 1.
